// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - Pong ball kinematics, wall/paddle bounce and miss detection
module ball_motion #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X_L   = 16,
  parameter int PADDLE_X_R   = 616,
  parameter int SPEEDUP_HITS = 4,
  parameter int MAX_SPEED    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       srv_l,
  input  logic       srv_r,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       miss_l,
  output logic       miss_r,
  output logic       hit,
  output logic [2:0] speed
);

  localparam int CW = $clog2(SPEEDUP_HITS + 1);

  // All position math is carried one bit wider than the outputs so that
  // sums and differences near the edges never wrap.
  localparam logic [10:0] LF      = 11'(PADDLE_X_L + PADDLE_W);
  localparam logic [10:0] RF      = 11'(PADDLE_X_R - BALL_SIZE);
  localparam logic [10:0] Y_MAX   = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] X_HOME  = 11'((H_RES - BALL_SIZE) / 2);
  localparam logic [10:0] Y_HOME  = 11'((V_RES - BALL_SIZE) / 2);
  localparam logic [10:0] BS      = 11'(BALL_SIZE);
  localparam logic [10:0] PH      = 11'(PADDLE_H);
  localparam logic [10:0] PH_HALF = 11'(PADDLE_H / 2);
  localparam logic [10:0] BS_HALF = 11'(BALL_SIZE / 2);
  localparam logic [2:0]  SPD_MAX = 3'(MAX_SPEED);
  localparam logic [CW-1:0] HITS_TOP = CW'(SPEEDUP_HITS);

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    MISSED
  } state_t;

  state_t state, state_n;

  // dx: 1 = moving right; dy: 1 = moving down
  logic          dx, dx_n;
  logic          dy, dy_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [10:0]   x_n, y_n;
  logic [2:0]    speed_n;
  logic          miss_l_n, miss_r_n, hit_n;

  logic [10:0] x11, y11, s11, pl11, pr11;
  logic [10:0] vy;
  logic        vdy;
  logic        overlap_l, overlap_r;
  logic        bounced;

  assign x11  = {1'b0, ball_x};
  assign y11  = {1'b0, ball_y};
  assign s11  = {8'd0, speed};
  assign pl11 = {1'b0, paddle_l_y};
  assign pr11 = {1'b0, paddle_r_y};

  // Paddle overlap is judged against the ball's position before this frame's move.
  assign overlap_l = (y11 + BS > pl11) && (y11 < pl11 + PH);
  assign overlap_r = (y11 + BS > pr11) && (y11 < pr11 + PH);

  // Launch height: ball centred on the paddle, kept inside the playfield.
  function automatic logic [10:0] serve_y(input logic [10:0] py);
    logic [10:0] c;
    c = py + PH_HALF;
    if (c < BS_HALF) begin
      serve_y = 11'd0;
    end else begin
      c = c - BS_HALF;
      serve_y = (c > Y_MAX) ? Y_MAX : c;
    end
  endfunction

  // Candidate vertical step with top/bottom wall reflection.
  always_comb begin
    vy  = y11;
    vdy = dy;
    if (dy) begin
      if (y11 + s11 >= Y_MAX) begin
        vy  = Y_MAX;
        vdy = 1'b0;
      end else begin
        vy = y11 + s11;
      end
    end else begin
      if (y11 <= s11) begin
        vy  = 11'd0;
        vdy = 1'b1;
      end else begin
        vy = y11 - s11;
      end
    end
  end

  // Next-state and next-datapath logic for serve, move, bounce and miss.
  always_comb begin
    state_n  = state;
    x_n      = x11;
    y_n      = y11;
    dx_n     = dx;
    dy_n     = dy;
    cnt_n    = cnt;
    speed_n  = speed;
    miss_l_n = miss_l;
    miss_r_n = miss_r;
    hit_n    = 1'b0;
    bounced  = 1'b0;

    case (state)
      IDLE, MISSED: begin
        // A simultaneous frame_tick is dropped; the first move waits for the next one.
        if (srv_l || srv_r) begin
          state_n  = MOVING;
          miss_l_n = 1'b0;
          miss_r_n = 1'b0;
          speed_n  = 3'd1;
          cnt_n    = '0;
          if (srv_l) begin
            x_n  = LF;
            y_n  = serve_y(pl11);
            dx_n = 1'b1;
            dy_n = 1'b1;
          end else begin
            x_n  = RF;
            y_n  = serve_y(pr11);
            dx_n = 1'b0;
            dy_n = 1'b0;
          end
        end
      end

      MOVING: begin
        if (frame_tick) begin
          y_n  = vy;
          dy_n = vdy;
          if (!dx) begin
            if (x11 <= LF + s11) begin
              if (overlap_l) begin
                x_n     = LF;
                dx_n    = 1'b1;
                bounced = 1'b1;
              end else begin
                state_n  = MISSED;
                miss_l_n = 1'b1;
                y_n      = y11;
                dy_n     = dy;
              end
            end else begin
              x_n = x11 - s11;
            end
          end else begin
            if (x11 + s11 >= RF) begin
              if (overlap_r) begin
                x_n     = RF;
                dx_n    = 1'b0;
                bounced = 1'b1;
              end else begin
                state_n  = MISSED;
                miss_r_n = 1'b1;
                y_n      = y11;
                dy_n     = dy;
              end
            end else begin
              x_n = x11 + s11;
            end
          end

          if (bounced) begin
            hit_n = 1'b1;
            if (cnt + CW'(1) >= HITS_TOP) begin
              cnt_n = '0;
              if (speed < SPD_MAX) begin
                speed_n = speed + 3'd1;
              end
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Ball position, direction, speed and flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ball_x <= X_HOME[9:0];
      ball_y <= Y_HOME[9:0];
      dx     <= 1'b1;
      dy     <= 1'b1;
      cnt    <= '0;
      speed  <= 3'd1;
      miss_l <= 1'b0;
      miss_r <= 1'b0;
      hit    <= 1'b0;
    end else begin
      ball_x <= x_n[9:0];
      ball_y <= y_n[9:0];
      dx     <= dx_n;
      dy     <= dy_n;
      cnt    <= cnt_n;
      speed  <= speed_n;
      miss_l <= miss_l_n;
      miss_r <= miss_r_n;
      hit    <= hit_n;
    end
  end

endmodule
